// File: rtl/mmm_pkg.sv
// Shared core parameters and the branch-info-queue entry type.
package mmm_pkg;

    localparam int XLEN      = 32;
    localparam int HLEN      = 10;
    localparam int OFFSET    = 2;
    localparam int BIQ_DEPTH = 8;

    typedef struct packed {
        logic [HLEN-1:0] index;
        logic            taken;
    } biq_entry_t;

endpackage

// File: rtl/branch_info_queue.sv
// FIFO of in-flight predicted branches; pops on resolve and emits a registered predictor update.
// Optional feature: define BIQ_MISPRED_CNT_EN to add a 32-bit mispredict counter output.
module branch_info_queue
    import mmm_pkg::*;
#(
    parameter int DEPTH = BIQ_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            push_valid_i,
    output logic            push_ready_o,
    input  logic [HLEN-1:0] push_index_i,
    input  logic            push_taken_i,
    input  logic            resolve_valid_i,
    input  logic            resolve_taken_i,
    output logic            res_valid_o,
    output logic [HLEN-1:0] res_index_o,
    output logic            res_taken_o,
    output logic            mispredict_o,
    output logic            empty_o,
    output logic            full_o
`ifdef BIQ_MISPRED_CNT_EN
    ,
    output logic [31:0]     mispred_count_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    biq_entry_t      mem_q [DEPTH];
    biq_entry_t      wr_entry_s;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             res_valid_q, res_valid_d;
    logic [HLEN-1:0]  res_index_q, res_index_d;
    logic             res_taken_q, res_taken_d;
    logic             mispred_q, mispred_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Flags come from registered occupancy only, so ready never depends on a same-cycle pop.
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == {CNT_W{1'b0}});
    assign push_ready_o = ~full_o;

    assign push_ok_s  = push_valid_i & ~full_o;
    assign pop_ok_s   = resolve_valid_i & ~empty_o;
    assign wr_entry_s = '{index: push_index_i, taken: push_taken_i};

    // Next-state for pointers, occupancy and the registered pop result; flush wins over everything.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        res_valid_d = 1'b0;
        res_index_d = res_index_q;
        res_taken_d = res_taken_q;
        mispred_d   = 1'b0;
        if (flush_i) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (pop_ok_s) begin
                head_d      = head_q + PTR_W'(1);
                res_valid_d = 1'b1;
                res_index_d = mem_q[head_q].index;
                res_taken_d = resolve_taken_i;
                mispred_d   = mem_q[head_q].taken ^ resolve_taken_i;
            end else begin
                head_d = head_q;
            end
            if (push_ok_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q      <= {PTR_W{1'b0}};
            tail_q      <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            res_valid_q <= 1'b0;
            res_index_q <= {HLEN{1'b0}};
            res_taken_q <= 1'b0;
            mispred_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_taken_q <= res_taken_d;
            mispred_q   <= mispred_d;
        end
    end

    // Entry storage is not reset: only slots between head and tail are ever read.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !flush_i) begin
            mem_q[tail_q] <= wr_entry_s;
        end
    end

    assign res_valid_o  = res_valid_q;
    assign res_index_o  = res_index_q;
    assign res_taken_o  = res_taken_q;
    assign mispredict_o = mispred_q;

`ifdef BIQ_MISPRED_CNT_EN
    logic [31:0] mispred_cnt_q;

    // Lifetime mispredict count; survives flushes, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mispred_cnt_q <= 32'd0;
        end else if (res_valid_q && mispred_q) begin
            mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end else begin
            mispred_cnt_q <= mispred_cnt_q;
        end
    end

    assign mispred_count_o = mispred_cnt_q;
`endif

endmodule
